simon_game_core: RTL

SIMON_GAME_CORE -- requirements
Module: simon_game_core

---
 rtl/simon_pkg.sv | 22 ++
 rtl/simon_lfsr.sv | 36 +++
 rtl/simon_game_core.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game core: FSM state codes and LFSR constants.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GEN      = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_INPUT    = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SUB = 8'hA5;

  // Right-shifting Galois step; the tap mask is folded in when bit 0 falls out.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Galois LFSR with seed load (zero seed replaced by LFSR_ZERO_SUB) and step enable.
// Exposes only the low OUT_W bits, which is all the sequence generator consumes.
module simon_lfsr #(
  parameter int OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [7:0]       seed,
  input  logic             step,
  output logic [OUT_W-1:0] rnd
);
  import simon_pkg::*;

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 8'h00) ? LFSR_ZERO_SUB : seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_ZERO_SUB;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/simon_game_core.sv
// Simon memory game: generates a random colour sequence, plays it back and checks presses.
// Optional per-press input timeout is compiled in with `define SIMON_TIMEOUT_EN.
module simon_game_core #(
  parameter int NUM_COLOURS    = 4,
  parameter int MAX_LEN        = 16,
  parameter int HOLD_CYCLES    = 10,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [7:0]                     seed,
  input  logic [NUM_COLOURS-1:0]         btn,
  output logic [NUM_COLOURS-1:0]         colour_out,
  output logic [2:0]                     state_dbg,
  output logic [$clog2(MAX_LEN+1)-1:0]   round,
  output logic                           win,
  output logic                           lose,
  output logic                           busy
);
  import simon_pkg::*;

  localparam int CW    = $clog2(NUM_COLOURS);
  localparam int RW    = $clog2(MAX_LEN + 1);
  localparam int IW    = $clog2(MAX_LEN);
  localparam int DEPTH = 1 << IW;
  localparam int TMAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [RW-1:0] MAX_LEN_R = RW'(MAX_LEN);
  localparam logic [IW-1:0] GEN_LAST  = IW'(MAX_LEN - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  if (!(NUM_COLOURS == 2 || NUM_COLOURS == 4 || NUM_COLOURS == 8)) begin : g_bad_colours
    $error("simon_game_core: NUM_COLOURS must be 2, 4 or 8");
  end
  if (MAX_LEN < 2 || MAX_LEN > 32) begin : g_bad_len
    $error("simon_game_core: MAX_LEN must be in 2..32");
  end
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_timing
    $error("simon_game_core: cycle counts must be at least 1");
  end

  state_e          state_q, state_d;
  logic [RW-1:0]   round_q, round_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   gen_cnt_q, gen_cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            start_prev_q;
  logic [NUM_COLOURS-1:0] btn_prev_q;

  // Sequence storage is never reset; GEN rewrites every entry before it is read.
  logic [CW-1:0]   seq_q [DEPTH];
  logic            seq_we;

  logic            lfsr_load, lfsr_step;
  logic [CW-1:0]   lfsr_rnd;

  logic            start_rise;
  logic            press;
  logic [CW-1:0]   btn_idx;
  logic [CW-1:0]   cur_colour;
  logic [RW-1:0]   last_idx;
  logic            at_last;

`ifdef SIMON_TIMEOUT_EN
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [OW-1:0] TO_LAST = OW'(TIMEOUT_CYCLES - 1);
  logic [OW-1:0]   to_cnt_q, to_cnt_d;
`endif

  simon_lfsr #(
    .OUT_W (CW)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed),
    .step (lfsr_step),
    .rnd  (lfsr_rnd)
  );

  assign start_rise = start & ~start_prev_q;
  // Only a clean zero -> one-hot transition counts as a press.
  assign press      = (btn_prev_q == '0) && $onehot(btn);
  assign cur_colour = seq_q[idx_q];
  assign last_idx   = round_q - RW'(1);
  assign at_last    = (RW'(idx_q) == last_idx);

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_COLOURS; i++) begin
      if (btn[i]) btn_idx = CW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    idx_d     = idx_q;
    gen_cnt_d = gen_cnt_q;
    tmr_d     = tmr_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    seq_we    = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start_rise) begin
          state_d   = ST_GEN;
          lfsr_load = 1'b1;
          gen_cnt_d = '0;
          round_d   = '0;
          idx_d     = '0;
        end
      end
      ST_GEN: begin
        seq_we    = 1'b1;
        lfsr_step = 1'b1;
        gen_cnt_d = gen_cnt_q + IW'(1);
        if (gen_cnt_q == GEN_LAST) begin
          round_d = RW'(1);
          idx_d   = '0;
          tmr_d   = '0;
          state_d = ST_SHOW_ON;
        end
      end
      ST_SHOW_ON: begin
        tmr_d = tmr_q + TW'(1);
        if (tmr_q == HOLD_LAST) begin
          tmr_d   = '0;
          state_d = ST_SHOW_OFF;
        end
      end
      ST_SHOW_OFF: begin
        tmr_d = tmr_q + TW'(1);
        if (tmr_q == GAP_LAST) begin
          tmr_d = '0;
          if (!at_last) begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_SHOW_ON;
          end else begin
            idx_d   = '0;
            state_d = ST_INPUT;
`ifdef SIMON_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end
      end
      ST_INPUT: begin
`ifdef SIMON_TIMEOUT_EN
        to_cnt_d = to_cnt_q + OW'(1);
`endif
        if (press) begin
`ifdef SIMON_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (btn_idx != cur_colour) begin
            state_d = ST_LOSE;
          end else if (!at_last) begin
            idx_d = idx_q + IW'(1);
          end else if (round_q != MAX_LEN_R) begin
            round_d = round_q + RW'(1);
            idx_d   = '0;
            tmr_d   = '0;
            state_d = ST_SHOW_ON;
          end else begin
            state_d = ST_WIN;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          state_d = ST_LOSE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      round_q      <= '0;
      idx_q        <= '0;
      gen_cnt_q    <= '0;
      tmr_q        <= '0;
      start_prev_q <= 1'b1;
      btn_prev_q   <= '1;
`ifdef SIMON_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      idx_q        <= idx_d;
      gen_cnt_q    <= gen_cnt_d;
      tmr_q        <= tmr_d;
      start_prev_q <= start;
      btn_prev_q   <= btn;
`ifdef SIMON_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (seq_we) seq_q[gen_cnt_q] <= lfsr_rnd;
  end

  // Lamp is decoded from the registered state so reset blanks it on the same edge.
  assign colour_out = (state_q == ST_SHOW_ON) ? (NUM_COLOURS'(1) << cur_colour) : '0;
  assign state_dbg  = state_q;
  assign round      = round_q;
  assign win        = (state_q == ST_WIN);
  assign lose       = (state_q == ST_LOSE);
  assign busy       = !(state_q == ST_IDLE || state_q == ST_WIN || state_q == ST_LOSE);

endmodule
